// File: rtl/uart_rx_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_ctrl
//
// Receive-side FIFO and line-status controller for a 16550-style UART.
// Characters from the framer are queued with their parity/framing/break flags.
// The head entry is presented to the register interface together with
// LSR-style status bits and the two receive interrupt sources (trigger level
// and character timeout).
//
// Parameters
//   DATA_WIDTH  character width
//   DEPTH       FIFO depth (power of two, 4..256)
//   OSR         baud_tick pulses per bit time
//
// Ports
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   baud_tick            oversample strobe used by the character timeout
//   rx_valid, rx_data    completed character from the framer
//   rx_pe, rx_fe, rx_bi  flags belonging to that character
//   rd_en                RBR read (pop), lsr_rd: LSR read (clears oe)
//   fifo_en              1 = FIFO mode, 0 = single holding register
//   fifo_clr             synchronous flush
//   trig_sel             receive trigger level select
//   frame_bits           bits per frame, used to scale the timeout
//   rd_data              head character
//   dr, oe, pe, fe, bi   line status bits 0..4
//   fifo_err             some stored character carries an error flag
//   count                current occupancy
//   rda_int, cto_int     data-available and character-timeout interrupts
// ---------------------------------------------------------------------------
module uart_rx_fifo_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int OSR        = 16
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    baud_tick,
   input  logic                    rx_valid,
   input  logic [DATA_WIDTH-1:0]   rx_data,
   input  logic                    rx_pe,
   input  logic                    rx_fe,
   input  logic                    rx_bi,
   input  logic                    rd_en,
   input  logic                    lsr_rd,
   input  logic                    fifo_en,
   input  logic                    fifo_clr,
   input  logic [1:0]              trig_sel,
   input  logic [3:0]              frame_bits,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    dr,
   output logic                    oe,
   output logic                    pe,
   output logic                    fe,
   output logic                    bi,
   output logic                    fifo_err,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    rda_int,
   output logic                    cto_int
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int EW   = DATA_WIDTH + 3;
   localparam int TMAX = 4 * 12 * OSR;
   localparam int TW   = $clog2(TMAX + 1);

   // Entry layout: {bi, fe, pe, data}
   logic [EW-1:0]  mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  err_cnt;
   logic [EW-1:0]  head;
   logic [TW-1:0]  tmo_cnt;
   logic           oe_q;
   logic           cto_q;
   logic           en_prev;
   logic           en_known;

   logic [CW-1:0]  capacity;
   logic [CW-1:0]  trig_level;
   logic           clr;
   logic           push;
   logic           pop;
   logic           overrun;
   logic           empty;
   logic [3:0]     fb_eff;
   logic [TW-1:0]  tmo_limit;
   logic [TW-1:0]  tmo_next;
   logic [EW-1:0]  wr_entry;
   logic [EW-1:0]  next_head;
   logic [CW-1:0]  cnt_next;
   logic [CW-1:0]  err_next;
   logic           wr_has_err;
   logic           head_has_err;

   // Transfer decisions. A pop frees a slot in the same cycle, so a push at
   // full is accepted when accompanied by a pop. Any flush (explicit, or a
   // mode change once the previous mode is known) cancels push and pop.
   always_comb begin
      empty        = (cnt == '0);
      capacity     = fifo_en ? CW'(DEPTH) : CW'(1);
      clr          = fifo_clr || (en_known && (fifo_en != en_prev));
      pop          = !clr && rd_en && !empty;
      push         = !clr && rx_valid && ((cnt < capacity) || pop);
      overrun      = !clr && rx_valid && (cnt >= capacity) && !pop;
      wr_entry     = {rx_bi, rx_fe, rx_pe, rx_data};
      wr_has_err   = rx_pe || rx_fe || rx_bi;
      head_has_err = |head[EW-1:DATA_WIDTH];
      cnt_next     = cnt + CW'(push) - CW'(pop);
      err_next     = err_cnt + CW'(push && wr_has_err) - CW'(pop && head_has_err);
   end

   // The head is kept in a register so rd_data is defined out of reset and
   // simply holds its last value once the FIFO drains.
   always_comb begin
      next_head = head;
      if (push && (empty || (pop && cnt == CW'(1)))) begin
         next_head = wr_entry;
      end else if (pop && cnt > CW'(1)) begin
         next_head = mem[rd_ptr + AW'(1)];
      end
   end

   // Trigger level and timeout threshold; illegal frame lengths use the
   // longest legal frame so the timeout never fires early.
   always_comb begin
      trig_level = CW'(1);
      if (fifo_en) begin
         case (trig_sel)
            2'b00:   trig_level = CW'(1);
            2'b01:   trig_level = CW'(DEPTH / 4);
            2'b10:   trig_level = CW'(DEPTH / 2);
            default: trig_level = CW'(DEPTH - 2);
         endcase
      end
      fb_eff    = ((frame_bits >= 4'd7) && (frame_bits <= 4'd12)) ? frame_bits : 4'd12;
      tmo_limit = TW'(4 * OSR * int'(fb_eff));
      tmo_next  = (baud_tick && (tmo_cnt < tmo_limit)) ? tmo_cnt + TW'(1) : tmo_cnt;
   end

   // Storage array; contents need no reset because occupancy gates every read.
   always_ff @(posedge PCLK) begin
      if (push) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   // Pointers, occupancy, error bookkeeping, overrun and timeout state.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         err_cnt  <= '0;
         head     <= '0;
         tmo_cnt  <= '0;
         oe_q     <= 1'b0;
         cto_q    <= 1'b0;
         en_prev  <= 1'b0;
         en_known <= 1'b0;
      end else begin
         en_prev  <= fifo_en;
         en_known <= 1'b1;
         head     <= next_head;

         if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            err_cnt <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            cnt     <= cnt_next;
            err_cnt <= err_next;
         end

         // An overrun in the same cycle as an LSR read leaves oe set.
         if (overrun) begin
            oe_q <= 1'b1;
         end else if (lsr_rd) begin
            oe_q <= 1'b0;
         end

         // Timeout counts quiet baud ticks while data waits; it saturates at
         // the threshold and the interrupt latches until activity or flush.
         if (clr || push || pop) begin
            tmo_cnt <= '0;
            cto_q   <= 1'b0;
         end else if (empty) begin
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_next;
            if (tmo_next >= tmo_limit) begin
               cto_q <= 1'b1;
            end
         end
      end
   end

   assign rd_data  = head[DATA_WIDTH-1:0];
   assign dr       = !empty;
   assign oe       = oe_q;
   assign pe       = !empty && head[DATA_WIDTH];
   assign fe       = !empty && head[DATA_WIDTH+1];
   assign bi       = !empty && head[DATA_WIDTH+2];
   assign fifo_err = (err_cnt != '0);
   assign count    = cnt;
   assign rda_int  = (cnt >= trig_level);
   assign cto_int  = cto_q;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo_ctrl
//
// Self-checking bench for uart_rx_fifo_ctrl (default parameters). A queue of
// characters models the FIFO; every cycle the model advances from the same
// inputs and all outputs are compared against it. Directed sequences cover
// ordering, overrun, full-with-pop, timeout, error flags, holding-register
// mode and reset, followed by randomized traffic with quiet phases.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo_ctrl;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int OSR   = 16;

   typedef struct packed {
      bit [7:0] data;
      bit       pe;
      bit       fe;
      bit       bi;
   } entry_t;

   logic                   PCLK;
   logic                   PRESETn;
   logic                   baud_tick;
   logic                   rx_valid;
   logic [DW-1:0]          rx_data;
   logic                   rx_pe;
   logic                   rx_fe;
   logic                   rx_bi;
   logic                   rd_en;
   logic                   lsr_rd;
   logic                   fifo_en;
   logic                   fifo_clr;
   logic [1:0]             trig_sel;
   logic [3:0]             frame_bits;
   logic [DW-1:0]          rd_data;
   logic                   dr;
   logic                   oe;
   logic                   pe;
   logic                   fe;
   logic                   bi;
   logic                   fifo_err;
   logic [$clog2(DEPTH):0] count;
   logic                   rda_int;
   logic                   cto_int;

   int num_checks = 0;
   int num_fails  = 0;

   // Reference model state
   entry_t   model_q[$];
   bit       m_oe;
   bit       m_cto;
   int       m_quiet;
   bit [7:0] m_last_rd;
   bit       m_prev_en;
   bit       m_en_known;

   uart_rx_fifo_ctrl #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .OSR        (OSR)
   ) dut (
      .PCLK       (PCLK),
      .PRESETn    (PRESETn),
      .baud_tick  (baud_tick),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_pe      (rx_pe),
      .rx_fe      (rx_fe),
      .rx_bi      (rx_bi),
      .rd_en      (rd_en),
      .lsr_rd     (lsr_rd),
      .fifo_en    (fifo_en),
      .fifo_clr   (fifo_clr),
      .trig_sel   (trig_sel),
      .frame_bits (frame_bits),
      .rd_data    (rd_data),
      .dr         (dr),
      .oe         (oe),
      .pe         (pe),
      .fe         (fe),
      .bi         (bi),
      .fifo_err   (fifo_err),
      .count      (count),
      .rda_int    (rda_int),
      .cto_int    (cto_int)
   );

   // 100 MHz clock
   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // Hard stop in case the stimulus never completes
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired before end of test");
      $fatal(1, "[TB] watchdog");
   end

   // Single comparison point: counts and reports each check
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      num_checks++;
      if (observed !== expected) begin
         num_fails++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      model_q.delete();
      m_oe       = 1'b0;
      m_cto      = 1'b0;
      m_quiet    = 0;
      m_last_rd  = 8'h00;
      m_prev_en  = 1'b0;
      m_en_known = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently applied
   task automatic modelStep();
      int     n;
      int     cap;
      int     fb;
      int     limit;
      bit     flush;
      bit     do_pop;
      bit     do_push;
      bit     ovr;
      entry_t e;
      n      = model_q.size();
      cap    = fifo_en ? DEPTH : 1;
      flush  = fifo_clr || (m_en_known && (fifo_en != m_prev_en));
      do_pop = !flush && rd_en && (n > 0);
      do_push = !flush && rx_valid && ((n < cap) || do_pop);
      ovr    = !flush && rx_valid && (n >= cap) && !do_pop;
      fb     = (frame_bits >= 7 && frame_bits <= 12) ? int'(frame_bits) : 12;
      limit  = 4 * fb * OSR;

      if (flush) begin
         model_q.delete();
      end else begin
         if (do_pop) void'(model_q.pop_front());
         if (do_push) begin
            e.data = rx_data;
            e.pe   = rx_pe;
            e.fe   = rx_fe;
            e.bi   = rx_bi;
            model_q.push_back(e);
         end
      end

      if (ovr) m_oe = 1'b1;
      else if (lsr_rd) m_oe = 1'b0;

      if (flush || do_push || do_pop) begin
         m_quiet = 0;
         m_cto   = 1'b0;
      end else if (n == 0) begin
         m_quiet = 0;
      end else begin
         if (baud_tick && m_quiet < limit) m_quiet++;
         if (m_quiet >= limit) m_cto = 1'b1;
      end

      if (model_q.size() > 0) m_last_rd = model_q[0].data;
      m_prev_en  = fifo_en;
      m_en_known = 1'b1;
   endtask

   // Compare every output against the model
   task automatic checkAll();
      int n;
      int trig;
      bit exp_pe;
      bit exp_fe;
      bit exp_bi;
      bit any_err;
      n       = model_q.size();
      exp_pe  = (n > 0) ? model_q[0].pe : 1'b0;
      exp_fe  = (n > 0) ? model_q[0].fe : 1'b0;
      exp_bi  = (n > 0) ? model_q[0].bi : 1'b0;
      any_err = 1'b0;
      foreach (model_q[i]) any_err |= (model_q[i].pe | model_q[i].fe | model_q[i].bi);
      if (!fifo_en) trig = 1;
      else case (trig_sel)
         2'b00:   trig = 1;
         2'b01:   trig = DEPTH / 4;
         2'b10:   trig = DEPTH / 2;
         default: trig = DEPTH - 2;
      endcase
      checkOutput("count",    32'(count),    32'(n));
      checkOutput("dr",       32'(dr),       32'(n != 0));
      checkOutput("oe",       32'(oe),       32'(m_oe));
      checkOutput("pe",       32'(pe),       32'(exp_pe));
      checkOutput("fe",       32'(fe),       32'(exp_fe));
      checkOutput("bi",       32'(bi),       32'(exp_bi));
      checkOutput("fifo_err", 32'(fifo_err), 32'(any_err));
      checkOutput("rd_data",  32'(rd_data),  32'(m_last_rd));
      checkOutput("rda_int",  32'(rda_int),  32'(n >= trig));
      checkOutput("cto_int",  32'(cto_int),  32'(m_cto));
   endtask

   // Apply one cycle of strobes, advance the model, then check after the edge
   task automatic applyStimulus(input bit v, input bit [7:0] d, input bit [2:0] flags,
                                input bit rd, input bit lsr, input bit clr, input bit tick);
      rx_valid  = v;
      rx_data   = d;
      rx_pe     = flags[0];
      rx_fe     = flags[1];
      rx_bi     = flags[2];
      rd_en     = rd;
      lsr_rd    = lsr;
      fifo_clr  = clr;
      baud_tick = tick;
      modelStep();
      @(posedge PCLK);
      #1;
      checkAll();
   endtask

   task automatic idleInputs();
      rx_valid  = 1'b0;
      rx_data   = '0;
      rx_pe     = 1'b0;
      rx_fe     = 1'b0;
      rx_bi     = 1'b0;
      rd_en     = 1'b0;
      lsr_rd    = 1'b0;
      fifo_clr  = 1'b0;
      baud_tick = 1'b0;
   endtask

   // Asynchronous reset in the middle of a cycle, checked while asserted
   task automatic pulseReset();
      idleInputs();
      PRESETn = 1'b0;
      #2;
      modelReset();
      checkAll();
      @(negedge PCLK);
      PRESETn = 1'b1;
      applyStimulus(0, 8'h00, 3'b000, 0, 0, 0, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2; i++) applyStimulus(0, 8'h00, 3'b000, 1, 0, 0, 0);
   endtask

   initial begin
      int  ticks;
      bit  rose;
      bit  quiet_phase;

      PRESETn    = 1'b0;
      fifo_en    = 1'b1;
      trig_sel   = 2'b10;
      frame_bits = 4'd10;
      idleInputs();
      modelReset();
      #12;
      $display("[TB] checking reset state");
      checkAll();
      @(negedge PCLK);
      PRESETn = 1'b1;
      applyStimulus(0, 8'h00, 3'b000, 0, 0, 0, 0);

      $display("[TB] ordered push/pop with trigger at DEPTH/2");
      for (int i = 0; i < 8; i++) applyStimulus(1, 8'(8'h41 + i), 3'b000, 0, 0, 0, 0);
      checkOutput("rda_after_8", 32'(rda_int), 32'd1);
      for (int i = 0; i < 8; i++) applyStimulus(0, 8'h00, 3'b000, 1, 0, 0, 0);

      $display("[TB] overrun at full");
      for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'(8'h80 + i), 3'b000, 0, 0, 0, 0);
      applyStimulus(1, 8'h55, 3'b000, 0, 0, 0, 0);
      checkOutput("oe_after_overrun", 32'(oe), 32'd1);
      applyStimulus(0, 8'h00, 3'b000, 0, 1, 0, 0);
      drain();

      $display("[TB] simultaneous push and pop at full");
      for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'(8'h20 + i), 3'b000, 0, 0, 0, 0);
      applyStimulus(1, 8'h77, 3'b000, 1, 0, 0, 0);
      drain();

      $display("[TB] character timeout");
      frame_bits = 4'd10;
      applyStimulus(1, 8'h3C, 3'b000, 0, 0, 0, 0);
      ticks = 0;
      rose  = 1'b0;
      for (int c = 0; c < 3000 && !rose; c++) begin
         applyStimulus(0, 8'h00, 3'b000, 0, 0, 0, c[0]);
         if (c[0]) ticks++;
         if (cto_int) rose = 1'b1;
      end
      checkOutput("cto_ticks", 32'(ticks), 32'd640);
      applyStimulus(0, 8'h00, 3'b000, 1, 0, 0, 0);

      $display("[TB] error flags and fifo_err");
      applyStimulus(1, 8'h10, 3'b010, 0, 0, 0, 0);
      applyStimulus(1, 8'h11, 3'b000, 0, 0, 0, 0);
      applyStimulus(0, 8'h00, 3'b000, 1, 0, 0, 0);
      applyStimulus(0, 8'h00, 3'b000, 1, 0, 0, 0);

      $display("[TB] holding register mode");
      fifo_en = 1'b0;
      applyStimulus(0, 8'h00, 3'b000, 0, 0, 0, 0);
      applyStimulus(1, 8'hAA, 3'b000, 0, 0, 0, 0);
      applyStimulus(1, 8'hBB, 3'b000, 0, 0, 0, 0);
      checkOutput("hold_rd_data", 32'(rd_data), 32'h0000_00AA);
      applyStimulus(0, 8'h00, 3'b000, 1, 1, 0, 0);
      fifo_en = 1'b1;
      applyStimulus(0, 8'h00, 3'b000, 0, 0, 0, 0);

      $display("[TB] flush and reset in flight");
      for (int i = 0; i < 5; i++) applyStimulus(1, 8'(8'h60 + i), 3'(i), 0, 0, 0, 1);
      applyStimulus(1, 8'h99, 3'b000, 1, 0, 1, 1);
      for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'h70 + i), 3'b001, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++) applyStimulus(0, 8'h00, 3'b000, 0, 0, 0, 1);
      pulseReset();
      applyStimulus(1, 8'h5A, 3'b000, 0, 0, 0, 0);
      checkOutput("first_after_reset", 32'(rd_data), 32'h0000_005A);

      $display("[TB] randomized traffic");
      for (int blk = 0; blk < 16; blk++) begin
         quiet_phase = (blk % 4 == 3);
         trig_sel    = 2'($urandom_range(0, 3));
         frame_bits  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(7, 12));
         if ($urandom_range(0, 3) == 0) fifo_en = ~fifo_en;
         for (int c = 0; c < (quiet_phase ? 900 : 300); c++) begin
            bit       v;
            bit       rd;
            bit [2:0] fl;
            if (quiet_phase) begin
               v  = ($urandom_range(0, 299) == 0);
               rd = ($urandom_range(0, 399) == 0);
            end else begin
               v  = ($urandom_range(0, 9) < 4);
               rd = ($urandom_range(0, 9) < 3);
            end
            fl = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            applyStimulus(v, 8'($urandom), fl, rd,
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 149) == 0),
                          quiet_phase ? 1'b1 : ($urandom_range(0, 1) == 1));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fails);
      $finish;
   end

endmodule
